// File: rtl/msx2_mapper_mem_pkg.sv
// Shared MSX mapper definitions: FSM state encoding, segment offset width and
// the segment masking helper used by every consumer of the mapper's segment output.
// Latency: n/a (types and pure functions only). Backpressure: n/a.
package msx2_mapper_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // 8-bit segment number concatenated with a 14-bit page offset.
    localparam int SEG_OFFSET_W = 22;

    // Segment counts are powers of two; size = 0 encodes 256, and the 8-bit
    // subtraction wraps it to an all-ones mask.
    function automatic logic [7:0] seg_mask(input logic [7:0] segment,
                                            input logic [7:0] size);
        return segment & (size - 8'd1);
    endfunction

endpackage

// File: rtl/msx2_mapper_rdbuf.sv
// One-entry read buffer (valid, address tag, data byte) for msx2_mapper_mem.
// Latency: combinational hit lookup; fill/update/invalidate take effect next clk.
// Backpressure: none; the owner sequences fill/update/invalidate.
// Ports: lookup_addr -> hit/hit_data; fill loads tag+data; update rewrites the
// data byte when wr_addr matches a valid tag; inval clears valid.
// The module only exists when MSX2_MAPPER_MEM_RDBUF_EN is defined, so the
// default build carries no unused top-level module.
`ifdef MSX2_MAPPER_MEM_RDBUF_EN
module msx2_mapper_rdbuf
    import msx2_mapper_mem_pkg::*;
#(
    parameter int AW = 27
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] lookup_addr,
    output logic          hit,
    output logic [7:0]    hit_data,
    input  logic          fill,
    input  logic          update,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          inval
);

    logic          valid;
    logic [AW-1:0] tag;
    logic [7:0]    data;

    assign hit      = valid && (tag == lookup_addr);
    assign hit_data = data;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= 8'h00;
        end else if (inval) begin
            valid <= 1'b0;
        end else if (fill) begin
            valid <= 1'b1;
            tag   <= wr_addr;
            data  <= wr_data;
        end else if (update && valid && (tag == wr_addr)) begin
            data  <= wr_data;
        end
    end

endmodule
`endif

// File: rtl/msx2_mapper_mem.sv
// MSX2 mapper memory side: masks segment, forms base+offset RAM address, and runs
// one req/ack backend transaction per CPU access, stalling the CPU via wait_n.
// Latency: wait_n low from the start cycle; q valid and wait_n high one clk after
// ram_ack. Backpressure: ram_req held until ram_ack or TIMEOUT cycles, then abort.
// Ports: cs/rd/wr/addr/data_in from the CPU slot; segment/size/base_addr from the
// mapper; q/wait_n to the CPU; ram_* to the RAM arbiter; sticky timeout_err.
// Optional: define MSX2_MAPPER_MEM_RDBUF_EN to add a one-entry read buffer.
module msx2_mapper_mem
    import msx2_mapper_mem_pkg::*;
#(
    parameter int RAM_AW  = 27,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              rd,
    input  logic              wr,
    input  logic [15:0]       addr,
    input  logic [7:0]        data_in,
    input  logic [7:0]        segment,
    input  logic [7:0]        size,
    input  logic [RAM_AW-1:0] base_addr,
    output logic [7:0]        q,
    output logic              wait_n,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [7:0]        ram_din,
    output logic              ram_we,
    output logic              ram_req,
    input  logic [7:0]        ram_dout,
    input  logic              ram_ack,
    output logic              timeout_err
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic                    act;
    logic                    act_q;
    logic                    start;
    logic                    aband;
    logic                    gone;
    logic                    tmo_hit;
    logic [7:0]              tmo_cnt;
    logic [SEG_OFFSET_W-1:0] offset;
    logic [RAM_AW-1:0]       addr_nxt;
    logic                    buf_hit;
    logic [7:0]              buf_dat;
    logic                    page_unused;

    // The page bits only choose which segment register feeds 'segment' upstream.
    assign page_unused = &{1'b0, addr[15:14]};

    assign act      = cs & (rd | wr);
    assign start    = act & ~act_q & ~reset & (state == IDLE);
    assign offset   = {seg_mask(segment, size), addr[13:0]};
    assign addr_nxt = base_addr + RAM_AW'(offset);
    assign tmo_hit  = (tmo_cnt == TMO_LAST) & ~ram_ack;
    // CPU left the cycle at some point during REQ: finish the backend access
    // but drop the result and skip DONE.
    assign gone     = aband | ~act;

`ifdef MSX2_MAPPER_MEM_RDBUF_EN
    logic buf_lookup_hit;

    msx2_mapper_rdbuf #(
        .AW (RAM_AW)
    ) u_rdbuf (
        .clk         (clk),
        .reset       (reset),
        .lookup_addr (addr_nxt),
        .hit         (buf_lookup_hit),
        .hit_data    (buf_dat),
        .fill        ((state == REQ) && ram_ack && !ram_we),
        .update      ((state == REQ) && ram_ack && ram_we),
        .wr_addr     (ram_addr),
        .wr_data     (ram_we ? ram_din : ram_dout),
        .inval       ((state == REQ) && tmo_hit)
    );

    // Only reads are served from the buffer; writes always reach the backend.
    assign buf_hit = buf_lookup_hit & ~wr;
`else
    assign buf_hit = 1'b0;
    assign buf_dat = 8'hFF;
`endif

    always_comb begin
        state_nxt = state;
        wait_n    = 1'b1;
        case (state)
            IDLE: begin
                if (start) begin
                    if (buf_hit) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = REQ;
                        wait_n    = 1'b0;  // stall in the start cycle itself
                    end
                end
            end
            REQ: begin
                wait_n = 1'b0;
                if (ram_ack || tmo_hit) begin
                    state_nxt = gone ? IDLE : DONE;
                end
            end
            DONE: begin
                if (!act) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            act_q       <= 1'b0;
            q           <= 8'hFF;
            ram_req     <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_din     <= 8'h00;
            timeout_err <= 1'b0;
            tmo_cnt     <= 8'h00;
            aband       <= 1'b0;
        end else begin
            state <= state_nxt;
            act_q <= act;
            case (state)
                IDLE: begin
                    if (start) begin
                        ram_addr <= addr_nxt;
                        ram_din  <= data_in;
                        ram_we   <= wr;  // rd and wr together count as a write
                        tmo_cnt  <= 8'h00;
                        aband    <= 1'b0;
                        if (buf_hit) begin
                            q <= buf_dat;
                        end else begin
                            ram_req <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (!act) begin
                        aband <= 1'b1;
                    end
                    if (ram_ack) begin
                        ram_req <= 1'b0;
                        q       <= (!ram_we && !gone) ? ram_dout : 8'hFF;
                    end else if (tmo_hit) begin
                        ram_req     <= 1'b0;
                        q           <= 8'hFF;
                        timeout_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                DONE: begin
                    if (!act) begin
                        q <= 8'hFF;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/msx2_mapper_mem.md
Name: msx2_mapper_mem

Overview:
- Memory-side consumer of the MSX2 memory mapper's per-page segment output.
- Takes a slot-selected CPU memory access and the 8-bit segment number for the current page, then forms the physical RAM address.
- Runs one req/ack transaction on the shared RAM backend per access, stalling the CPU through wait_n until the access completes.
- Sits between the slot decoder and the RAM arbiter, one instance per mapper device.

Parameters:
- RAM_AW, 27, physical RAM address width in bytes.
- TIMEOUT, 255, clock cycles without ram_ack before the access is aborted (range 2..255).

Ports:
- clk  in  1  system clock (cpu_bus clock).
- reset  in  1  synchronous, active-high reset.
- cs  in  1  slot/subslot selects this device for the current memory cycle.
- rd  in  1  CPU memory read strobe.
- wr  in  1  CPU memory write strobe.
- addr  in  16  CPU address.
- data_in  in  8  CPU write data.
- segment  in  8  segment number for page addr[15:14], from the mapper register file.
- size  in  8  segment count, a power of two; 0 means 256.
- base_addr  in  RAM_AW  physical base of this mapper's RAM region.
- q  out  8  read data to the CPU bus; FFh when not driving.
- wait_n  out  1  CPU wait, active low.
- ram_addr  out  RAM_AW  backend byte address.
- ram_din  out  8  backend write data.
- ram_we  out  1  1 = write, 0 = read; valid while ram_req is high.
- ram_req  out  1  backend request.
- ram_dout  in  8  backend read data; valid in the cycle ram_ack is high.
- ram_ack  in  1  one-cycle completion pulse.
- timeout_err  out  1  sticky flag, set on an aborted access.

Behaviour:
- Reset values:
  - state = IDLE; q = FFh; wait_n = 1; ram_req = 0; ram_we = 0.
  - ram_addr = 0; ram_din = 0; timeout_err = 0.
- Access start: the rising edge of act = cs & (rd | wr), registered. An access starts only from IDLE.
- If rd and wr are both high, the access is a write.
- Address formation, registered at start:
  - seg_m = segment & (size - 1), computed in 8-bit arithmetic, so size = 0 gives mask FFh.
  - offset = {seg_m, addr[13:0]}, 22 bits.
  - ram_addr = base_addr + zero-extended offset, modulo 2^RAM_AW (wraps, no error).
- State machine:
  - IDLE → REQ on access start:
    - wait_n is driven low combinationally in the start cycle, so the CPU is stalled with no lost cycle.
    - ram_addr, ram_din and ram_we are latched.
  - REQ:
    - ram_req = 1 and remains high until ram_ack or timeout.
    - The timeout counter increments each cycle.
    - On ram_ack: q ← ram_dout for a read (a write leaves q = FFh); ram_req ← 0; go to DONE.
    - If the counter reaches TIMEOUT without ram_ack: ram_req ← 0; q ← FFh; timeout_err ← 1; go to DONE.
  - DONE:
    - wait_n = 1.
    - q holds its value while act stays high.
    - When act falls: q ← FFh, go to IDLE.
- Latency: read data appears on q one cycle after ram_ack. wait_n rises in that same cycle.
- Late ram_ack arriving outside REQ is ignored.
- act falling while in REQ (CPU abandoned the cycle): the transaction completes, result is discarded, FSM returns straight to IDLE.
- The segment and addr inputs may change after start without effect on the in-flight access.
- Reset mid-transaction:
  - All state is cleared at the next clk edge; ram_req drops with no handshake.
  - An ack arriving in IDLE is ignored.
- timeout_err clears only on reset.
- ram_din and ram_we do not change while ram_req = 1.

Optional Feature:
- Macro: MSX2_MAPPER_MEM_RDBUF_EN.
- When defined, a one-entry read buffer is added (valid bit, RAM_AW-bit tag, data byte):
  - Buffer hit: a read whose ram_addr equals the tag with valid = 1 goes IDLE → DONE in the start cycle. There is no ram_req, wait_n stays 1, and q = buffered byte next cycle.
  - Fill: every completed backend read loads the buffer.
  - Write to the tagged address: updates the buffer data byte.
  - Invalidation: a timeout or reset clears valid.
- When undefined, every access goes to the backend, with identical behaviour to the state machine above.

Decomposition:
- Shared MSX package holds:
  - the state enum typedef (IDLE, REQ, DONE);
  - the constant SEG_OFFSET_W = 22;
  - a function seg_mask(segment, size) returning seg_m, reusable by other mapper consumers.
- One sub-module, msx2_mapper_rdbuf, contains the optional read buffer. It is instantiated only under the macro.

Test Plan:
- Basic read: size=04h, base=100000h, segment=06h, addr=8123h, backend acks after 3 cycles with A5h.
  - ram_addr = 100000h + (02h<<14 | 0123h) = 108123h, ram_we = 0.
  - wait_n is low for 5 cycles.
  - q = A5h until rd drops, then FFh.
- Write with size=0: segment=FFh, addr=4000h, data=3Ch, ack after 1 cycle.
  - ram_addr = base + 3FC000h, ram_we = 1, ram_din = 3Ch.
  - q remains FFh.
- Timeout: TIMEOUT=8, no ack.
  - ram_req is high for exactly 8 cycles.
  - q = FFh, wait_n returns to 1, timeout_err = 1.
  - A late ack is ignored.
- Reset during REQ:
  - ram_req = 0 and wait_n = 1 on the next edge.
  - An ack asserted 2 cycles later leaves state IDLE and q = FFh.
- Back-to-back:
  - Read then write to the same address, act dropping for 1 cycle in between.
  - Two distinct ram_req pulses; no access is started while act stays high.
- With MSX2_MAPPER_MEM_RDBUF_EN defined:
  - A repeat read of 108123h issues no ram_req and keeps wait_n = 1, with q = A5h.
  - After a write of 5Ah to that address, a re-read returns 5Ah.
